// File: rtl/sipo_frame_ctrl.sv
// Serial-in parallel-out framing controller: shifts WIDTH bits MSB first and
// hands each completed word to a registered valid/ready output buffer.
module sipo_frame_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             sin_start,
  output logic [WIDTH-1:0] pdata,
  output logic             pvalid,
  input  logic             pready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  assign shifted = {shreg_q[WIDTH-2:0], sin};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    pdata_d     = pdata_q;
    pvalid_d    = pvalid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    complete    = 1'b0;

    case (state_q)
      IDLE: begin
        if (sin_en && sin_start) begin
          shreg_d = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      default: begin
        // A restart wins over completion, even on the last bit.
        if (sin_en && sin_start) begin
          shreg_d     = shifted;
          cnt_d       = CW'(1);
          frame_err_d = 1'b1;
        end else if (sin_en && (cnt_q == CW'(WIDTH - 1))) begin
          shreg_d  = shifted;
          cnt_d    = '0;
          state_d  = IDLE;
          complete = 1'b1;
        end else if (sin_en) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
    endcase

    // The buffer slot frees up in the same cycle it is consumed.
    if (complete) begin
      if (!pvalid_q || pready) begin
        pdata_d  = shifted;
        pvalid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pvalid_q && pready) begin
      pvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      pdata_q     <= '0;
      pvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      pdata_q     <= pdata_d;
      pvalid_q    <= pvalid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pdata     = pdata_q;
  assign pvalid    = pvalid_q;
  assign busy      = (state_q == SHIFT);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sipo_frame_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_en = 1'b0;
  logic         sin_start = 1'b0;
  logic         pready = 1'b0;
  logic [W-1:0] pdata;
  logic         pvalid;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_en    (sin_en),
    .sin_start (sin_start),
    .pdata     (pdata),
    .pvalid    (pvalid),
    .pready    (pready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a run of bits opened by a start marker;
  // the W-th bit closes it and the word is offered to a one-entry buffer.
  logic        m_in_frame = 1'b0;
  int          m_nbits = 0;
  logic [31:0] m_acc = '0;
  logic        m_pvalid = 1'b0;
  logic [W-1:0] m_pdata = '0;
  logic        m_fe = 1'b0;
  logic        m_ov = 1'b0;

  always @(posedge clk) begin
    logic done;
    done = 1'b0;
    if (!rst_n) begin
      m_in_frame = 1'b0;
      m_nbits    = 0;
      m_acc      = '0;
      m_pvalid   = 1'b0;
      m_pdata    = '0;
      m_fe       = 1'b0;
      m_ov       = 1'b0;
    end else begin
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (sin_en && sin_start) begin
        m_fe       = m_in_frame;
        m_in_frame = 1'b1;
        m_nbits    = 1;
        m_acc      = {31'd0, sin};
      end else if (sin_en && m_in_frame) begin
        m_acc   = m_acc * 2 + {31'd0, sin};
        m_nbits = m_nbits + 1;
        if (m_nbits == W) begin
          done       = 1'b1;
          m_in_frame = 1'b0;
        end
      end
      if (done) begin
        if (!m_pvalid || pready) begin
          m_pdata  = m_acc[W-1:0];
          m_pvalid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_pvalid && pready) begin
        m_pvalid = 1'b0;
      end
    end
  end

  bit armed = 1'b0;
  int busy_cnt = 0, pv_cnt = 0, fe_cnt = 0, ov_cnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      check("pdata", {24'd0, pdata}, {24'd0, m_pdata});
      check("pvalid", {31'd0, pvalid}, {31'd0, m_pvalid});
      check("busy", {31'd0, busy}, {31'd0, m_in_frame});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      check("overrun", {31'd0, overrun}, {31'd0, m_ov});
      busy_cnt += int'(busy);
      pv_cnt   += int'(pvalid);
      fe_cnt   += int'(frame_err);
      ov_cnt   += int'(overrun);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) begin
      sin_en = 1'b0; sin_start = 1'b0; pready = rdy;
      tick();
    end
  endtask

  // Sends the top nbits of word MSB first; rdy_last applies on the final bit.
  task automatic send(input logic [W-1:0] word, input int nbits, input bit gaps,
                      input logic rdy, input logic rdy_last);
    for (int i = 0; i < nbits; i++) begin
      sin_en = 1'b1; sin_start = (i == 0); sin = word[W-1-i];
      pready = (i == nbits - 1) ? rdy_last : rdy;
      tick();
      if (gaps && i != nbits - 1) begin
        sin_en = 1'b0; sin_start = 1'b0; pready = rdy;
        tick();
      end
    end
    sin_en = 1'b0; sin_start = 1'b0; pready = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sin_en = 1'b0; sin_start = 1'b0; pready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int b0, p0, f0, o0;
    do_reset();
    armed = 1'b1;
    check("rst_pdata", {24'd0, pdata}, 32'd0);
    check("rst_pvalid", {31'd0, pvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Basic frame with pready high: single-cycle valid, 7 busy cycles.
    b0 = busy_cnt; p0 = pv_cnt;
    send(8'hB2, W, 1'b0, 1'b1, 1'b1);
    check("t1_pvalid_now", {31'd0, pvalid}, 32'd1);
    check("t1_pdata", {24'd0, pdata}, 32'hB2);
    idle(3, 1'b1);
    check("t1_busy_cycles", busy_cnt - b0, 32'd7);
    check("t1_pvalid_cycles", pv_cnt - p0, 32'd1);
    check("t1_pdata_hold", {24'd0, pdata}, 32'hB2);

    // Gapped strobes and stalled consumer.
    send(8'hB2, W, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("t2_pvalid_stall", {31'd0, pvalid}, 32'd1);
    check("t2_pdata", {24'd0, pdata}, 32'hB2);
    idle(1, 1'b1);
    check("t2_pvalid_drop", {31'd0, pvalid}, 32'd0);

    // Restart after 5 bits.
    f0 = fe_cnt; p0 = pv_cnt;
    send(8'hFF, 5, 1'b0, 1'b1, 1'b1);
    send(8'h3C, W, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("t3_fe_pulses", fe_cnt - f0, 32'd1);
    check("t3_pdata", {24'd0, pdata}, 32'h3C);
    check("t3_words", pv_cnt - p0, 32'd1);

    // Overrun while A5 pending.
    o0 = ov_cnt;
    send(8'hA5, W, 1'b0, 1'b0, 1'b0);
    send(8'h5A, W, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("t4_ov_pulses", ov_cnt - o0, 32'd1);
    check("t4_pdata", {24'd0, pdata}, 32'hA5);
    idle(2, 1'b1);

    // Consumer accepts on the very cycle the next word completes.
    o0 = ov_cnt;
    send(8'hA5, W, 1'b0, 1'b0, 1'b0);
    send(8'h3C, W, 1'b0, 1'b0, 1'b1);
    check("t5_pvalid", {31'd0, pvalid}, 32'd1);
    check("t5_pdata", {24'd0, pdata}, 32'h3C);
    check("t5_no_ov", ov_cnt - o0, 32'd0);
    idle(2, 1'b1);

    // Reset mid-frame, then unmarked bits are ignored.
    send(8'hF0, 4, 1'b0, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sin_en = 1'b1; sin_start = 1'b0; sin = 1'b1; pready = 1'b1;
      tick();
    end
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_pvalid", {31'd0, pvalid}, 32'd0);
    check("t6_pdata", {24'd0, pdata}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      sin_en    = ($urandom_range(0, 3) != 0);
      sin_start = ($urandom_range(0, 10) == 0);
      sin       = $urandom_range(0, 1);
      pready    = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
